// File: rtl/array_pkg.sv
// Shared types and constants for the systolic MAC array.
package array_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN
  } state_t;

  // Clamp limits for a w-bit signed accumulator (callers truncate to w bits).
  function automatic logic [63:0] sat_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int unsigned w);
    return ~sat_pos(w);
  endfunction

endpackage

// File: rtl/mac_pe.sv
// Single systolic processing element: operand/valid pipeline registers and a
// wrap-or-saturate multiply-accumulate with synchronous clear.
module mac_pe
  import array_pkg::*;
#(
  parameter int unsigned IWIDTH = 16,
  parameter int unsigned OWIDTH = 32,
  parameter int unsigned SAT    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic signed [IWIDTH-1:0] a_in,
  input  logic                     a_vld_in,
  input  logic signed [IWIDTH-1:0] b_in,
  input  logic                     b_vld_in,
  output logic signed [IWIDTH-1:0] a_out,
  output logic                     a_vld_out,
  output logic signed [IWIDTH-1:0] b_out,
  output logic                     b_vld_out,
  output logic signed [OWIDTH-1:0] acc
);

  localparam logic [OWIDTH-1:0] ACC_MAX = OWIDTH'(sat_pos(OWIDTH));
  localparam logic [OWIDTH-1:0] ACC_MIN = OWIDTH'(sat_neg(OWIDTH));

  logic signed [2*IWIDTH-1:0] prod;
  logic signed [OWIDTH-1:0]   prod_ext;
  logic        [OWIDTH:0]     sum;
  logic                       ovf;
  logic signed [OWIDTH-1:0]   acc_d;

  always_comb begin
    prod     = (2*IWIDTH)'(a_out) * (2*IWIDTH)'(b_out);
    prod_ext = OWIDTH'(prod);
    // One guard bit: overflow shows up as disagreement between the top two bits.
    sum      = {acc[OWIDTH-1], acc} + {prod_ext[OWIDTH-1], prod_ext};
    ovf      = sum[OWIDTH] ^ sum[OWIDTH-1];
    acc_d    = sum[OWIDTH-1:0];
    if ((SAT != 0) && ovf) begin
      acc_d = sum[OWIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
      if (clr) begin
        acc <= '0;
      end else if (a_vld_out && b_vld_out) begin
        acc <= acc_d;
      end
    end
  end

endmodule

// File: rtl/array_systolic_seq.sv
// Output-stationary HEIGHT x WIDTH systolic MAC array with internal operand
// skew, a LOAD/FLUSH/DRAIN sequencer and a row-at-a-time drain port.
module array_systolic_seq
  import array_pkg::*;
#(
  parameter int unsigned HEIGHT = 12,
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned IWIDTH = 16,
  parameter int unsigned OWIDTH = 32,
  parameter int unsigned KWIDTH = 10,
  parameter int unsigned SAT    = 0,
  localparam int unsigned RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic        [KWIDTH-1:0] k_len,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] ifm  [HEIGHT],
  input  logic signed [IWIDTH-1:0] wght [WIDTH],
  output logic signed [OWIDTH-1:0] ofm  [WIDTH],
  output logic                     ofm_valid,
  input  logic                     ofm_ready,
  output logic        [RW-1:0]     ofm_row,
  output logic                     ofm_last
);

  localparam int unsigned FLUSH_CYC = HEIGHT + WIDTH - 1;
  localparam int unsigned FW        = $clog2(FLUSH_CYC + 1);

  state_t            state_q, state_d;
  logic [KWIDTH-1:0] k_q, beat_cnt_q;
  logic [FW-1:0]     flush_cnt_q;
  logic [RW-1:0]     row_q;
  logic              done_q;
  logic              accept_start, beat, drain_hs, last_row;

  logic signed [IWIDTH-1:0] a_pipe [HEIGHT][WIDTH+1];
  logic                     a_vld  [HEIGHT][WIDTH+1];
  logic signed [IWIDTH-1:0] b_pipe [HEIGHT+1][WIDTH];
  logic                     b_vld  [HEIGHT+1][WIDTH];
  logic signed [OWIDTH-1:0] acc    [HEIGHT][WIDTH];

  assign accept_start = (state_q == IDLE) && start;
  assign beat         = (state_q == LOAD) && in_valid;
  assign drain_hs     = (state_q == DRAIN) && ofm_ready;
  assign last_row     = (row_q == RW'(HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (k_len != '0) ? LOAD : DRAIN;
      LOAD:  if (beat && (beat_cnt_q == k_q - KWIDTH'(1))) state_d = FLUSH;
      FLUSH: if (flush_cnt_q == FW'(FLUSH_CYC - 1)) state_d = DRAIN;
      DRAIN: if (drain_hs && last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= drain_hs && last_row;
      if (accept_start) begin
        k_q         <= k_len;
        beat_cnt_q  <= '0;
        flush_cnt_q <= '0;
        row_q       <= '0;
      end
      if (beat) beat_cnt_q <= beat_cnt_q + KWIDTH'(1);
      if (state_q == FLUSH) flush_cnt_q <= flush_cnt_q + FW'(1);
      if (drain_hs) row_q <= last_row ? '0 : row_q + RW'(1);
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign in_ready  = (state_q == LOAD);
  assign ofm_valid = (state_q == DRAIN);
  assign ofm_row   = row_q;
  assign ofm_last  = (state_q == DRAIN) && last_row;

  always_comb begin
    for (int unsigned w = 0; w < WIDTH; w++) begin
      ofm[w] = (state_q == DRAIN) ? acc[row_q][w] : '0;
    end
  end

  // Row h enters h cycles late; the PE's own input register supplies the +1.
  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    if (h == 0) begin : g_direct
      assign a_pipe[0][0] = ifm[0];
      assign a_vld[0][0]  = beat;
    end else begin : g_skew
      logic signed [IWIDTH-1:0] sr [h];
      logic                     sv [h];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < h; i++) begin
            sr[i] <= '0;
            sv[i] <= 1'b0;
          end
        end else begin
          sr[0] <= ifm[h];
          sv[0] <= beat;
          for (int unsigned i = 1; i < h; i++) begin
            sr[i] <= sr[i-1];
            sv[i] <= sv[i-1];
          end
        end
      end
      assign a_pipe[h][0] = sr[h-1];
      assign a_vld[h][0]  = sv[h-1];
    end
  end

  for (genvar w = 0; w < WIDTH; w++) begin : g_col
    if (w == 0) begin : g_direct
      assign b_pipe[0][0] = wght[0];
      assign b_vld[0][0]  = beat;
    end else begin : g_skew
      logic signed [IWIDTH-1:0] sr [w];
      logic                     sv [w];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < w; i++) begin
            sr[i] <= '0;
            sv[i] <= 1'b0;
          end
        end else begin
          sr[0] <= wght[w];
          sv[0] <= beat;
          for (int unsigned i = 1; i < w; i++) begin
            sr[i] <= sr[i-1];
            sv[i] <= sv[i-1];
          end
        end
      end
      assign b_pipe[0][w] = sr[w-1];
      assign b_vld[0][w]  = sv[w-1];
    end
  end

  for (genvar h = 0; h < HEIGHT; h++) begin : g_pe_r
    for (genvar w = 0; w < WIDTH; w++) begin : g_pe_c
      mac_pe #(
        .IWIDTH(IWIDTH),
        .OWIDTH(OWIDTH),
        .SAT   (SAT)
      ) u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept_start),
        .a_in     (a_pipe[h][w]),
        .a_vld_in (a_vld[h][w]),
        .b_in     (b_pipe[h][w]),
        .b_vld_in (b_vld[h][w]),
        .a_out    (a_pipe[h][w+1]),
        .a_vld_out(a_vld[h][w+1]),
        .b_out    (b_pipe[h+1][w]),
        .b_vld_out(b_vld[h+1][w]),
        .acc      (acc[h][w])
      );
    end
  end

endmodule

// File: tb/tb_array_systolic_seq.sv
// Scoreboard bench: two 2x2 arrays (wrap and saturate) in lockstep plus one
// default-size array; expected drain rows are queued, monitors pop and compare.
module tb_array_systolic_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]   row;
    logic         last;
    logic [447:0] data;
  } exp_t;

  exp_t wr_q[$], sa_q[$], d_q[$];

  // Shared stimulus for the two small arrays
  logic              s_start, s_in_valid, s_ofm_ready;
  logic [9:0]        s_klen;
  logic signed [7:0] s_ifm [2];
  logic signed [7:0] s_wght [2];

  logic               wr_busy, wr_done, wr_in_ready, wr_ofm_valid, wr_ofm_last;
  logic [0:0]         wr_ofm_row;
  logic signed [15:0] wr_ofm [2];
  logic               sa_busy, sa_done, sa_in_ready, sa_ofm_valid, sa_ofm_last;
  logic [0:0]         sa_ofm_row;
  logic signed [15:0] sa_ofm [2];

  logic               d_start, d_in_valid, d_ofm_ready;
  logic [9:0]         d_klen;
  logic signed [15:0] d_ifm [12];
  logic signed [15:0] d_wght [14];
  logic               d_busy, d_done, d_in_ready, d_ofm_valid, d_ofm_last;
  logic [3:0]         d_ofm_row;
  logic signed [31:0] d_ofm [14];

  array_systolic_seq #(.HEIGHT(2), .WIDTH(2), .IWIDTH(8), .OWIDTH(16), .KWIDTH(10), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(s_start), .k_len(s_klen), .busy(wr_busy), .done(wr_done),
    .in_valid(s_in_valid), .in_ready(wr_in_ready), .ifm(s_ifm), .wght(s_wght), .ofm(wr_ofm),
    .ofm_valid(wr_ofm_valid), .ofm_ready(s_ofm_ready), .ofm_row(wr_ofm_row), .ofm_last(wr_ofm_last));

  array_systolic_seq #(.HEIGHT(2), .WIDTH(2), .IWIDTH(8), .OWIDTH(16), .KWIDTH(10), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .k_len(s_klen), .busy(sa_busy), .done(sa_done),
    .in_valid(s_in_valid), .in_ready(sa_in_ready), .ifm(s_ifm), .wght(s_wght), .ofm(sa_ofm),
    .ofm_valid(sa_ofm_valid), .ofm_ready(s_ofm_ready), .ofm_row(sa_ofm_row), .ofm_last(sa_ofm_last));

  array_systolic_seq u_dflt (
    .clk(clk), .rst_n(rst_n), .start(d_start), .k_len(d_klen), .busy(d_busy), .done(d_done),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .ifm(d_ifm), .wght(d_wght), .ofm(d_ofm),
    .ofm_valid(d_ofm_valid), .ofm_ready(d_ofm_ready), .ofm_row(d_ofm_row), .ofm_last(d_ofm_last));

  logic [31:0]  wr_flat, sa_flat;
  logic [447:0] d_flat;
  always_comb begin
    wr_flat = {wr_ofm[1], wr_ofm[0]};
    sa_flat = {sa_ofm[1], sa_ofm[0]};
    d_flat  = '0;
    for (int w = 0; w < 14; w++) d_flat[w*32 +: 32] = d_ofm[w];
  end

  int sb_ifm [4][2];
  int sb_wght [4][2];
  int d_bifm [3][12];
  int d_bwght [3][14];

  task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic mon_pop(input int which, input string tag, input logic [3:0] row,
                         input logic last, input logic [447:0] data);
    exp_t e;
    int   n;
    case (which)
      0:       n = wr_q.size();
      1:       n = sa_q.size();
      default: n = d_q.size();
    endcase
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_extra_row got row=%0d exp=none pending", tag, row);
    end else begin
      case (which)
        0:       e = wr_q.pop_front();
        1:       e = sa_q.pop_front();
        default: e = d_q.pop_front();
      endcase
      chk({tag, "_row_last"}, 448'({row, last}), 448'({e.row, e.last}));
      chk({tag, "_ofm"}, data, e.data);
    end
  endtask

  always @(negedge clk) if (rst_n && wr_ofm_valid && s_ofm_ready)
    mon_pop(0, "wrap", 4'(wr_ofm_row), wr_ofm_last, 448'(wr_flat));
  always @(negedge clk) if (rst_n && sa_ofm_valid && s_ofm_ready)
    mon_pop(1, "sat", 4'(sa_ofm_row), sa_ofm_last, 448'(sa_flat));
  always @(negedge clk) if (rst_n && d_ofm_valid && d_ofm_ready)
    mon_pop(2, "dflt", d_ofm_row, d_ofm_last, d_flat);

  task automatic push_s(input bit sat, input int row, input int v0, input int v1);
    exp_t e;
    e            = '0;
    e.row        = 4'(row);
    e.last       = (row == 1);
    e.data[15:0] = 16'(v0);
    e.data[31:16] = 16'(v1);
    if (sat) sa_q.push_back(e);
    else wr_q.push_back(e);
  endtask

  task automatic set_sb(input int i, input int i0, input int i1, input int w0, input int w1);
    sb_ifm[i][0]  = i0;
    sb_ifm[i][1]  = i1;
    sb_wght[i][0] = w0;
    sb_wght[i][1] = w1;
  endtask

  // hold>0: keep ofm_ready low that many cycles once row 0 is presented (h0/h1 = its values)
  task automatic small_job(input int k, input bit stall, input int hold, input bit poke,
                           input int h0, input int h1);
    bit rdy, seen_rdy, dw, ds;
    int guard;
    seen_rdy = 1'b0;
    @(posedge clk); #1;
    s_start = 1'b1;
    s_klen  = 10'(k);
    @(posedge clk); #1;
    s_start     = 1'b0;
    s_klen      = '0;
    s_ofm_ready = (hold == 0);
    for (int i = 0; i < k; i++) begin
      if (stall) begin
        s_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_in_valid = 1'b1;
      for (int j = 0; j < 2; j++) begin
        s_ifm[j]  = 8'(sb_ifm[i][j]);
        s_wght[j] = 8'(sb_wght[i][j]);
      end
      guard = 0;
      do begin
        @(negedge clk);
        rdy = wr_in_ready && sa_in_ready;
        @(posedge clk); #1;
        guard++;
      end while (!rdy && guard < 20);
      chk("beat_accept", 448'(rdy), 448'(1'b1));
    end
    s_in_valid = 1'b0;
    if (poke) begin
      s_start = 1'b1;
      s_klen  = 10'd3;
      @(posedge clk); #1;
      s_start = 1'b0;
      s_klen  = '0;
    end
    if (hold > 0) begin
      guard = 0;
      while (!wr_ofm_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      repeat (hold) begin
        @(negedge clk);
        chk("hold_stable", 448'({wr_ofm_valid, wr_ofm_row, wr_flat}),
            448'({1'b1, 1'b0, 16'(h1), 16'(h0)}));
      end
      @(posedge clk); #1;
      s_ofm_ready = 1'b1;
    end
    dw = 1'b0;
    ds = 1'b0;
    guard = 0;
    while (!(dw && ds) && guard < 100) begin
      @(negedge clk);
      seen_rdy = seen_rdy | wr_in_ready | sa_in_ready;
      dw = dw | wr_done;
      ds = ds | sa_done;
      guard++;
    end
    chk("done_seen", 448'({dw, ds}), 448'(2'b11));
    @(negedge clk);
    chk("done_pulse_end", 448'({wr_done, sa_done, wr_busy, sa_busy}), 448'(0));
    if (k == 0) chk("k0_no_in_ready", 448'(seen_rdy), 448'(0));
  endtask

  task automatic d_job(input bit stall);
    exp_t   e;
    longint s;
    int     guard;
    bit     rdy, dn;
    for (int h = 0; h < 12; h++) begin
      e      = '0;
      e.row  = 4'(h);
      e.last = (h == 11);
      for (int w = 0; w < 14; w++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += longint'(d_bifm[k][h]) * longint'(d_bwght[k][w]);
        e.data[w*32 +: 32] = s[31:0];
      end
      d_q.push_back(e);
    end
    @(posedge clk); #1;
    d_start = 1'b1;
    d_klen  = 10'd3;
    @(posedge clk); #1;
    d_start = 1'b0;
    d_klen  = '0;
    for (int k = 0; k < 3; k++) begin
      if (stall) begin
        d_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      d_in_valid = 1'b1;
      for (int h = 0; h < 12; h++) d_ifm[h] = 16'(d_bifm[k][h]);
      for (int w = 0; w < 14; w++) d_wght[w] = 16'(d_bwght[k][w]);
      guard = 0;
      do begin
        @(negedge clk);
        rdy = d_in_ready;
        @(posedge clk); #1;
        guard++;
      end while (!rdy && guard < 20);
      chk("dflt_beat_accept", 448'(rdy), 448'(1'b1));
    end
    d_in_valid = 1'b0;
    dn = 1'b0;
    guard = 0;
    while (!dn && guard < 200) begin
      @(negedge clk);
      dn = d_done;
      guard++;
    end
    chk("dflt_done", 448'(dn), 448'(1'b1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    s_start     = 1'b0;
    s_klen      = '0;
    s_in_valid  = 1'b0;
    s_ofm_ready = 1'b1;
    d_start     = 1'b0;
    d_klen      = '0;
    d_in_valid  = 1'b0;
    d_ofm_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      s_ifm[j]  = '0;
      s_wght[j] = '0;
    end
    for (int h = 0; h < 12; h++) d_ifm[h] = '0;
    for (int w = 0; w < 14; w++) d_wght[w] = '0;
    for (int k = 0; k < 3; k++) begin
      for (int h = 0; h < 12; h++) d_bifm[k][h] = (h == 11) ? -32768 : (k + 1) * (h + 1) - 9;
      for (int w = 0; w < 14; w++) d_bwght[k][w] = (w == 13) ? -32768 : 3 * w - 5 * k + 2;
    end

    repeat (2) @(negedge clk);
    chk("rst_wrap", 448'({wr_busy, wr_done, wr_in_ready, wr_ofm_valid, wr_ofm_last, wr_ofm_row, wr_flat}), 448'(0));
    chk("rst_sat", 448'({sa_busy, sa_done, sa_in_ready, sa_ofm_valid, sa_ofm_last, sa_ofm_row, sa_flat}), 448'(0));
    chk("rst_dflt", 448'({d_busy, d_done, d_in_ready, d_ofm_valid, d_ofm_last, d_ofm_row}), 448'(0));
    chk("rst_dflt_ofm", d_flat, 448'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 2x2 basic, with a start pulse during FLUSH that must be ignored
    set_sb(0, 1, 2, 3, 4);
    for (int s = 0; s < 2; s++) begin
      push_s(s[0], 0, 3, 4);
      push_s(s[0], 1, 6, 8);
    end
    small_job(1, 1'b0, 0, 1'b1, 0, 0);

    // 4 x 127*127: wraps to -1020, saturates to 32767
    for (int i = 0; i < 4; i++) set_sb(i, 127, 127, 127, 127);
    push_s(1'b0, 0, -1020, -1020);
    push_s(1'b0, 1, -1020, -1020);
    push_s(1'b1, 0, 32767, 32767);
    push_s(1'b1, 1, 32767, 32767);
    small_job(4, 1'b0, 0, 1'b0, 0, 0);

    // Negative overflow on row 1, with stalls: 4 x -16256 = -65024
    for (int i = 0; i < 4; i++) set_sb(i, 127, -128, 127, 127);
    push_s(1'b0, 0, -1020, -1020);
    push_s(1'b0, 1, 512, 512);
    push_s(1'b1, 0, 32767, 32767);
    push_s(1'b1, 1, -32768, -32768);
    small_job(4, 1'b1, 0, 1'b0, 0, 0);

    // k_len = 0: straight to drain, all-zero rows
    for (int s = 0; s < 2; s++) begin
      push_s(s[0], 0, 0, 0);
      push_s(s[0], 1, 0, 0);
    end
    small_job(0, 1'b0, 0, 1'b0, 0, 0);

    // Two beats, ofm_ready held low for 5 cycles on row 0
    set_sb(0, 3, -2, 5, 7);
    set_sb(1, -4, 6, 1, -3);
    for (int s = 0; s < 2; s++) begin
      push_s(s[0], 0, 11, 33);
      push_s(s[0], 1, -4, -32);
    end
    small_job(2, 1'b0, 5, 1'b0, 11, 33);

    // Reset during LOAD, then a clean job
    @(posedge clk); #1;
    s_start = 1'b1;
    s_klen  = 10'd4;
    @(posedge clk); #1;
    s_start    = 1'b0;
    s_in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      s_ifm[j]  = 8'sd127;
      s_wght[j] = 8'sd127;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b0;
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_load", 448'({wr_busy, wr_in_ready, sa_busy, sa_in_ready, wr_ofm_valid, wr_flat}), 448'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_sb(0, 1, 1, 2, 2);
    for (int s = 0; s < 2; s++) begin
      push_s(s[0], 0, 2, 2);
      push_s(s[0], 1, 2, 2);
    end
    small_job(1, 1'b0, 0, 1'b0, 0, 0);

    // Default geometry: stalled and unstalled runs against the same expectation
    d_job(1'b1);
    d_job(1'b0);

    repeat (5) @(negedge clk);
    chk("queues_empty", 448'({wr_q.size(), sa_q.size(), d_q.size()}), 448'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/array_systolic_seq.md
ARRAY_SYSTOLIC_SEQ -- requirements
Module: array_systolic_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-002 Parameter HEIGHT, default 12, SHALL set the number of PE rows, one ifm lane per row.
REQ-003 Parameter WIDTH, default 14, SHALL set the number of PE columns, one wght lane and one ofm lane per column.
REQ-004 Parameter IWIDTH, default 16, SHALL set the signed operand width.
REQ-005 Parameter OWIDTH, default 32, SHALL set the signed accumulator width.
REQ-006 Parameter KWIDTH, default 10, SHALL set the width of k_len.
REQ-007 Parameter SAT, default 0, SHALL select accumulation mode: 0 = two's-complement wrap, 1 = saturate.
REQ-008 Port clk, input, 1 bit: clock.
REQ-009 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-010 Port start, input, 1 bit: launches a job; sampled only in IDLE.
REQ-011 Port k_len, input, KWIDTH bits: reduction depth, captured on an accepted start.
REQ-012 Port busy, output, 1 bit: high in every state except IDLE.
REQ-013 Port done, output, 1 bit: one-cycle pulse after the last row is drained.
REQ-014 Port in_valid / in_ready, input / output, 1 bit each: operand-beat handshake.
REQ-015 Port ifm, input, HEIGHT x IWIDTH signed: unskewed row operands.
REQ-016 Port wght, input, WIDTH x IWIDTH signed: unskewed column operands.
REQ-017 Port ofm, output, WIDTH x OWIDTH signed: one accumulator row.
REQ-018 Port ofm_valid / ofm_ready, output / input, 1 bit each: drain handshake.
REQ-019 Port ofm_row, output, clog2(HEIGHT) bits: row index of the current ofm.
REQ-020 Port ofm_last, output, 1 bit: marks row HEIGHT-1.

Function
REQ-021 States SHALL be IDLE, LOAD, FLUSH, DRAIN.
REQ-022 Transitions:
- IDLE->LOAD on start with k_len>0.
- IDLE->DRAIN on start with k_len==0.
- LOAD->FLUSH on the k_len-th accepted beat.
- FLUSH->DRAIN after HEIGHT+WIDTH-1 cycles.
- DRAIN->IDLE on the ofm handshake with ofm_last.
REQ-023 An accepted start SHALL zero every accumulator in the same edge.
REQ-024 in_ready SHALL be high only in LOAD; a beat is accepted on in_valid && in_ready.
REQ-025 Operand skew and propagation SHALL be internal: row h delayed h cycles, column w delayed w cycles, one register per PE hop; a beat accepted at cycle t SHALL reach PE(h,w) at t+1+h+w.
REQ-026 Each operand SHALL carry a valid bit; a PE SHALL accumulate only when its valid is set.
REQ-027 Stall cycles (in_valid low in LOAD) SHALL inject bubbles and SHALL NOT alter any result.
REQ-028 Product SHALL be the full 2*IWIDTH signed product, sign-extended to OWIDTH before the add.
REQ-029 With SAT=1, overflow SHALL clamp to +(2^(OWIDTH-1)-1) or -2^(OWIDTH-1); with SAT=0 it SHALL wrap.
REQ-030 In DRAIN, ofm_valid SHALL be high and ofm SHALL present row ofm_row, starting at 0 and advancing by one per handshake; ofm SHALL hold stable while ofm_ready is low.
REQ-031 done SHALL pulse in the cycle after the final drain handshake.
REQ-032 start SHALL be ignored while busy.
REQ-033 Reset values: busy, done, in_ready, ofm_valid, ofm_last = 0; ofm_row = 0; ofm = 0.

Reset
REQ-034 Assertion of rst_n SHALL, at any time including mid-job, force IDLE and clear accumulators, skew/pipeline registers, valid bits and counters.

Structure
REQ-035 The state enum and the SAT clamp constants SHALL live in the shared package array_pkg.
REQ-036 One sub-module, mac_pe, SHALL implement a single PE: operand and valid registers, multiply, wrap/saturate accumulate, and synchronous clear.

Verification
REQ-037 2x2 configuration, k_len=1, ifm={1,2}, wght={3,4} -> rows {3,4} and {6,8}, then a done pulse.
REQ-038 Default configuration, k_len=3, in_valid low on alternate cycles -> results identical to an unstalled run.
REQ-039 SAT=1, OWIDTH=16, k_len=4, all operands 127 -> 4*16129 overflows, so every ofm = 32767; with SAT=0 the same stimulus -> every ofm = 64516-65536 = -1020.
REQ-040 k_len=0 -> no in_ready; HEIGHT drain rows, all zero.
REQ-041 ofm_ready held low for 5 cycles during DRAIN -> ofm and ofm_row stable throughout.
REQ-042 rst_n asserted mid-LOAD, then a new job with k_len=1, ifm=all 1, wght=all 2 -> every ofm = 2, with no residue from the aborted job.
